// File: rtl/l2_data_array_ctrl.sv
`timescale 1ns/1ps
// Requester-side controller for the single-port L2 data SRAM: zero-fills the array after
// reset, maps valid/ready requests onto the macro port and buffers read data in a small FIFO.
module l2_data_array_ctrl #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_WMASKS = DATA_WIDTH / 8,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(RSP_DEPTH);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  rd_inflight_q;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];

    logic          running;
    logic          push;
    logic          pop;
    logic          rd_credit;
    logic          hs;
    logic          rd_hs;
    logic [CW:0]   credit_used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign running   = (state_q == ST_RUN);
    assign push      = rd_inflight_q;
    assign pop       = rsp_valid && rsp_ready;
    // Reads need a free slot counting the in-flight word; a same-cycle pop frees one.
    assign credit_used = {1'b0, count_q} + (CW + 1)'(rd_inflight_q) - (CW + 1)'(pop);
    assign rd_credit = (credit_used < DEPTH_C);
    assign req_ready = running && (req_we || rd_credit);
    assign hs        = req_valid && req_ready;
    assign rd_hs     = hs && !req_we;
    assign rsp_valid = (count_q != '0);
    assign rsp_rdata = fifo_q[rd_ptr_q];
    assign init_done = running;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
            if (init_cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // The macro has no reset, so its port is forced idle while rst_n is low.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (rst_n) begin
            if (!running) begin
                sram_csb0   = 1'b0;
                sram_web0   = 1'b0;
                sram_wmask0 = '1;
                sram_addr0  = init_cnt_q;
            end else begin
                sram_csb0   = !hs;
                sram_web0   = !req_we;
                sram_wmask0 = req_wmask;
                sram_addr0  = req_addr;
                sram_din0   = req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            rd_inflight_q <= rd_hs;
            count_q       <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= sram_dout0;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

endmodule

// File: tb/tb_l2_data_array_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for l2_data_array_ctrl: behavioural SRAM macro, shadow-array reference
// model, directed scenarios followed by randomized traffic with random consumer backpressure.
module tb_l2_data_array_ctrl;

    localparam int DW    = 256;
    localparam int AW    = 4;
    localparam int NM    = DW / 8;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [NM-1:0] req_wmask = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_csb0;
    logic          sram_web0;
    logic [NM-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;

    l2_data_array_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_WMASKS(NM),
        .RSP_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .init_done  (init_done),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_wmask0(sram_wmask0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit strict = 1'b0;
    bit rr_rand = 1'b0;

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Macro model: registered read, masked write; contents start as garbage.
    logic [DW-1:0] sram_mem [WORDS];
    bit seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < WORDS; i++) sram_mem[i] <= rand256();
            seeded <= 1'b1;
        end else if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < NM; b++)
                    if (sram_wmask0[b]) sram_mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
            end else begin
                sram_dout0 <= sram_mem[sram_addr0];
            end
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            acc;
    } exp_t;

    logic [DW-1:0] shadow [WORDS];
    exp_t exp_q [$];
    exp_t mon_e;

    task automatic check_eq(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic zero_shadow();
        for (int i = 0; i < WORDS; i++) shadow[i] = '0;
    endtask

    // Reference model update at the moment a request is accepted.
    task automatic accept(input logic we, input logic [AW-1:0] addr, input logic [NM-1:0] mask,
                          input logic [DW-1:0] data);
        exp_t e;
        if (we) begin
            for (int b = 0; b < NM; b++)
                if (mask[b]) shadow[addr][b*8 +: 8] = data[b*8 +: 8];
        end else begin
            e.data = shadow[addr];
            e.acc  = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [NM-1:0] mask,
                        input logic [DW-1:0] data, input bit must_now);
        int  waits = 0;
        bit  done = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wmask = mask;
        req_wdata = data;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                accept(we, addr, mask, data);
                done = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                waits++;
                if (waits > 60) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: addr %0d we %0d not accepted in %0d cycles", addr, we, waits);
                    done = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        req_valid = 1'b0;
        if (must_now) check_int("req_ready_immediate_waits", waits, 0);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_int("drain_pending", exp_q.size(), 0);
    endtask

    // Releases reset and checks the zero-fill sequence edge by edge.
    task automatic release_and_check_init();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= WORDS; k++) begin
            @(posedge clk);
            #1;
            if (k < WORDS) begin
                check_int("init_done_early", int'(init_done), 0);
                check_int("init_req_ready", int'(req_ready), 0);
                check_int("init_csb0", int'(sram_csb0), 0);
                check_int("init_web0", int'(sram_web0), 0);
                check_int("init_addr0", int'(sram_addr0), k);
            end else begin
                check_int("init_done_rise", int'(init_done), 1);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_int({tag, "_req_ready"}, int'(req_ready), 0);
        check_int({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, '0);
        check_int({tag, "_init_done"}, int'(init_done), 0);
        check_int({tag, "_csb0"}, int'(sram_csb0), 1);
        check_int({tag, "_web0"}, int'(sram_web0), 1);
        check_eq({tag, "_wmask0"}, DW'(sram_wmask0), '0);
        check_int({tag, "_addr0"}, int'(sram_addr0), 0);
        check_eq({tag, "_din0"}, sram_din0, '0);
    endtask

    // Monitor: a response is consumed on the edge following a negedge with valid && ready.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got %h expected no response", rsp_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("rsp_rdata", rsp_rdata, mon_e.data);
                    if (strict) check_int("rsp_latency_cycle", cyc, mon_e.acc + 1);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [NM-1:0] m;
        int            sel;
        zero_shadow();

        // Reset state and zero-fill; array contents start random so zeros prove the fill.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_and_check_init();

        strict = 1'b1;
        for (int a = 0; a < WORDS; a++) send(1'b0, AW'(a), '0, '0, 1'b1);
        drain();

        // Write followed immediately by read of the same address.
        send(1'b1, AW'(3), '1, {32{8'hA5}}, 1'b1);
        send(1'b0, AW'(3), '0, '0, 1'b1);
        drain();

        // Byte mask: only byte 0 is cleared; an all-zero mask leaves memory alone.
        send(1'b1, AW'(5), '1, {32{8'hFF}}, 1'b1);
        send(1'b1, AW'(5), NM'(1), '0, 1'b1);
        send(1'b1, AW'(5), '0, rand256(), 1'b1);
        send(1'b0, AW'(5), '0, '0, 1'b1);
        drain();

        // Consumer stalled: two reads fit, the third stalls, a write still goes through.
        strict = 1'b0;
        rsp_ready = 1'b0;
        send(1'b0, AW'(1), '0, '0, 1'b1);
        send(1'b0, AW'(5), '0, '0, 1'b1);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = AW'(4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_int("read_stall_req_ready", int'(req_ready), 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check_int("stall_rsp_valid", int'(rsp_valid), 1);
        send(1'b1, AW'(6), '1, rand256(), 1'b1);
        rsp_ready = 1'b1;
        send(1'b0, AW'(4), '0, '0, 1'b1);
        send(1'b0, AW'(6), '0, '0, 1'b1);
        drain();

        // Streaming reads: one accepted per cycle, responses on consecutive cycles.
        strict = 1'b1;
        for (int a = 0; a < 8; a++) send(1'b0, AW'(a), '0, '0, 1'b1);
        drain();

        // Randomized traffic with random consumer backpressure.
        strict = 1'b0;
        rr_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 3);
            m = (sel == 0) ? '0 : (sel == 1) ? '1 : NM'($urandom);
            d = rand256();
            send(1'($urandom_range(0, 1)), AW'($urandom_range(0, WORDS - 1)), m, d, 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rr_rand = 1'b0;
        #0;
        rsp_ready = 1'b1;
        drain();

        // Reset with two responses pending: everything is dropped and the fill restarts.
        send(1'b1, AW'(9), '1, rand256(), 1'b1);
        rsp_ready = 1'b0;
        send(1'b0, AW'(9), '0, '0, 1'b1);
        send(1'b0, AW'(3), '0, '0, 1'b1);
        @(posedge clk);
        #1;
        check_int("pending_rsp_valid", int'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        zero_shadow();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        release_and_check_init();
        strict = 1'b1;
        send(1'b0, AW'(9), '0, '0, 1'b1);
        send(1'b0, AW'(3), '0, '0, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
